// File: rtl/fpu_lsu_if.sv
// Request, memory-bus and write-back signals of the FP load/store unit.
// slave = the LSU itself, master = the pipeline/memory side driving it.
interface fpu_lsu_if #(
  parameter int FLEN   = 64,
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic              req_dbl;
  logic [ADDR_W-1:0] req_addr;
  logic [FLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [BUS_W-1:0]  mem_store;
  logic [BUS_W-1:0]  mem_load;
  logic              mem_busy;
  logic              reg_w;
  logic [4:0]        reg_rd;
  logic [FLEN-1:0]   reg_wdata;
  logic              busy;
  logic              exception;

  modport slave (
    input  req_valid, req_load, req_store, req_dbl, req_addr, req_wdata, req_rd,
    input  flush, mem_load, mem_busy,
    output req_ready, mem_addr, mem_ren, mem_wen, mem_store,
    output reg_w, reg_rd, reg_wdata, busy, exception
  );

  modport master (
    output req_valid, req_load, req_store, req_dbl, req_addr, req_wdata, req_rd,
    output flush, mem_load, mem_busy,
    input  req_ready, mem_addr, mem_ren, mem_wen, mem_store,
    input  reg_w, reg_rd, reg_wdata, busy, exception
  );
endinterface

// File: rtl/fpu_lsu.sv
// FP load/store unit: splits FLW/FSW/FLD/FSD into 32-bit bus beats and writes loads back.
// Optional macro FPU_LSU_NANBOX_EN: NaN-box word loads into a 64-bit register.
module fpu_lsu #(
  parameter int FLEN   = 64,
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 32
) (
  input logic     CLK,
  input logic     nRST,
  fpu_lsu_if.slave bus
);

`ifdef FPU_LSU_NANBOX_EN
  localparam logic [31:0] WORD_UPPER = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] WORD_UPPER = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              beat_q, beat_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic              dbl_q, dbl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              flush_pend_q, flush_pend_d;
  logic              exc_q, exc_d;

  logic              accept_s;
  logic              illegal_s;
  logic              xfer_s;
  logic              beat_done_s;
  logic              last_s;
  logic              reg_w_s;
  logic [BUS_W-1:0]  store_s;

  assign accept_s    = bus.req_valid && (state_q == IDLE) && (bus.req_load || bus.req_store);
  assign illegal_s   = (bus.req_load && bus.req_store)
                     || (bus.req_dbl && (FLEN == 32))
                     || (!bus.req_dbl && (bus.req_addr[1:0] != 2'b00))
                     || (bus.req_dbl && (bus.req_addr[2:0] != 3'b000));
  assign xfer_s      = (state_q == XFER);
  assign beat_done_s = xfer_s && !bus.mem_busy;
  assign last_s      = (beat_q == dbl_q);

  // Next-state, operand latching and load-data capture.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    load_d       = load_q;
    store_d      = store_q;
    dbl_d        = dbl_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    res_d        = res_q;
    rd_d         = rd_q;
    flush_pend_d = flush_pend_q;
    exc_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && illegal_s) begin
          exc_d = 1'b1;
        end else if (accept_s) begin
          state_d      = XFER;
          beat_d       = 1'b0;
          load_d       = bus.req_load;
          store_d      = bus.req_store;
          dbl_d        = bus.req_dbl;
          addr_d       = bus.req_addr;
          wdata_d      = 64'(bus.req_wdata);
          rd_d         = bus.req_rd;
          flush_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (beat_done_s) begin
          // A flushed op still finishes its current beat, then drops the rest.
          if (load_q && !dbl_q) begin
            res_d = {WORD_UPPER, bus.mem_load[31:0]};
          end else if (load_q && !beat_q) begin
            res_d[31:0] = bus.mem_load[31:0];
          end else if (load_q) begin
            res_d[63:32] = bus.mem_load[31:0];
          end else begin
            res_d = res_q;
          end
          if (bus.flush || flush_pend_q) begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
          end else if (last_s) begin
            state_d = DONE;
          end else begin
            beat_d = 1'b1;
          end
        end else begin
          state_d = XFER;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      beat_q       <= 1'b0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      dbl_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 64'h0;
      res_q        <= 64'h0;
      rd_q         <= 5'd0;
      flush_pend_q <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      load_q       <= load_d;
      store_q      <= store_d;
      dbl_q        <= dbl_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      res_q        <= res_d;
      rd_q         <= rd_d;
      flush_pend_q <= flush_pend_d;
      exc_q        <= exc_d;
    end
  end

  // Outputs decode straight from the flops so reset clears them immediately.
  assign reg_w_s = (state_q == DONE) && load_q && !bus.flush;
  assign store_s = (xfer_s && store_q) ? (beat_q ? wdata_q[63:32] : wdata_q[31:0]) : '0;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = xfer_s;
  assign bus.mem_ren   = xfer_s && load_q;
  assign bus.mem_wen   = xfer_s && store_q;
  assign bus.mem_addr  = xfer_s ? (addr_q + ADDR_W'({beat_q, 2'b00})) : '0;
  assign bus.mem_store = store_s;
  assign bus.reg_w     = reg_w_s;
  assign bus.reg_rd    = reg_w_s ? rd_q : 5'd0;
  assign bus.reg_wdata = reg_w_s ? res_q[FLEN-1:0] : '0;
  assign bus.exception = exc_q;

endmodule

// File: tb/tb_fpu_lsu.sv
// Directed self-checking bench for fpu_lsu (FLEN=64).
module tb_fpu_lsu;
  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef FPU_LSU_NANBOX_EN
  localparam logic [63:0] WL_EXP = 64'hFFFFFFFF3F800000;
`else
  localparam logic [63:0] WL_EXP = 64'h000000003F800000;
`endif

  fpu_lsu_if #(.FLEN(64), .BUS_W(32), .ADDR_W(32)) bus ();

  fpu_lsu #(.FLEN(64), .BUS_W(32), .ADDR_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_req();
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    bus.req_dbl   = 1'b0;
  endtask

  task automatic test_reset();
    clr_req();
    bus.req_addr = 32'h0; bus.req_wdata = 64'h0; bus.req_rd = 5'd0;
    bus.flush = 1'b0; bus.mem_load = 32'h0; bus.mem_busy = 1'b0;
    nRST = 1'b0;
    #12;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end n_checks++;
    if ({bus.mem_ren, bus.mem_wen, bus.reg_w, bus.exception} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes got %b exp 0000", {bus.mem_ren, bus.mem_wen, bus.reg_w, bus.exception}); end n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_store !== 32'h0) begin n_fail++; $display("FAIL rst_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_store); end n_checks++;
    if (bus.reg_wdata !== 64'h0 || bus.reg_rd !== 5'd0) begin n_fail++; $display("FAIL rst_wb got %h/%0d exp 0/0", bus.reg_wdata, bus.reg_rd); end n_checks++;
    cyc();
    nRST = 1'b1;
    cyc();
  endtask

  task automatic test_word_load(input logic [31:0] addr, input logic [31:0] data, input logic [63:0] exp);
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_addr = addr; bus.req_rd = 5'd7;
    #1;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wl_ready got %b exp 1", bus.req_ready); end n_checks++;
    cyc();
    clr_req();
    bus.mem_load = data; bus.mem_busy = 1'b0;
    #1;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== addr) begin n_fail++; $display("FAIL wl_ren got %b@%h exp 1@%h", bus.mem_ren, bus.mem_addr, addr); end n_checks++;
    if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL wl_busy got %b/%b exp 1/0", bus.busy, bus.req_ready); end n_checks++;
    cyc();
    #1;
    if (bus.reg_w !== 1'b1 || bus.reg_rd !== 5'd7) begin n_fail++; $display("FAIL wl_regw got %b/%0d exp 1/7", bus.reg_w, bus.reg_rd); end n_checks++;
    if (bus.reg_wdata !== exp) begin n_fail++; $display("FAIL wl_data got %h exp %h", bus.reg_wdata, exp); end n_checks++;
    if (bus.mem_ren !== 1'b0) begin n_fail++; $display("FAIL wl_ren_done got %b exp 0", bus.mem_ren); end n_checks++;
    cyc();
    #1;
    if (bus.reg_w !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wl_idle got %b/%b exp 0/1", bus.reg_w, bus.req_ready); end n_checks++;
  endtask

  task automatic test_double_store();
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_dbl = 1'b1;
    bus.req_addr = 32'h208; bus.req_wdata = 64'h400921FB54442D18;
    cyc();
    clr_req();
    for (int k = 0; k < 4; k++) begin
      bus.mem_busy = (k < 3);
      #1;
      if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h208 || bus.mem_store !== 32'h54442D18) begin
        n_fail++; $display("FAIL ds_beat0 cyc%0d got %b %h %h exp 1 208 54442d18", k, bus.mem_wen, bus.mem_addr, bus.mem_store);
      end
      n_checks++;
      cyc();
    end
    bus.mem_busy = 1'b0;
    #1;
    if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h20C || bus.mem_store !== 32'h400921FB) begin
      n_fail++; $display("FAIL ds_beat1 got %b %h %h exp 1 20c 400921fb", bus.mem_wen, bus.mem_addr, bus.mem_store);
    end
    n_checks++;
    cyc();
    #1;
    if (bus.mem_wen !== 1'b0 || bus.reg_w !== 1'b0 || bus.mem_store !== 32'h0) begin n_fail++; $display("FAIL ds_done got %b/%b/%h exp 0/0/0", bus.mem_wen, bus.reg_w, bus.mem_store); end n_checks++;
    cyc();
    #1;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ds_ready got %b exp 1", bus.req_ready); end n_checks++;
  endtask

  task automatic test_double_load();
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_dbl = 1'b1; bus.req_addr = 32'h400; bus.req_rd = 5'd3;
    cyc();
    clr_req();
    bus.mem_load = 32'h11111111;
    #1;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h400) begin n_fail++; $display("FAIL dl_beat0 got %b@%h exp 1@400", bus.mem_ren, bus.mem_addr); end n_checks++;
    cyc();
    bus.mem_load = 32'h22222222;
    #1;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h404) begin n_fail++; $display("FAIL dl_beat1 got %b@%h exp 1@404", bus.mem_ren, bus.mem_addr); end n_checks++;
    cyc();
    #1;
    if (bus.reg_w !== 1'b1 || bus.reg_wdata !== 64'h2222222211111111 || bus.reg_rd !== 5'd3) begin
      n_fail++; $display("FAIL dl_wb got %b %h %0d exp 1 2222222211111111 3", bus.reg_w, bus.reg_wdata, bus.reg_rd);
    end
    n_checks++;
    cyc();
  endtask

  task automatic test_illegal(input logic ld, input logic st, input logic dbl, input logic [31:0] addr);
    bus.req_valid = 1'b1; bus.req_load = ld; bus.req_store = st; bus.req_dbl = dbl; bus.req_addr = addr;
    cyc();
    clr_req();
    #1;
    if (bus.exception !== 1'b1) begin n_fail++; $display("FAIL ill_exc addr %h got %b exp 1", addr, bus.exception); end n_checks++;
    if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ill_bus got ren %b wen %b rdy %b exp 0 0 1", bus.mem_ren, bus.mem_wen, bus.req_ready);
    end
    n_checks++;
    cyc();
    #1;
    if (bus.exception !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ill_pulse got %b/%b exp 0/0", bus.exception, bus.busy); end n_checks++;
  endtask

  task automatic test_ignore();
    bus.req_valid = 1'b1; bus.req_addr = 32'h100;
    cyc();
    clr_req();
    #1;
    if ({bus.busy, bus.mem_ren, bus.mem_wen, bus.exception, bus.req_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL ign got %b exp 00001", {bus.busy, bus.mem_ren, bus.mem_wen, bus.exception, bus.req_ready});
    end
    n_checks++;
  endtask

  task automatic test_flush();
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_dbl = 1'b1; bus.req_addr = 32'h300;
    cyc();
    clr_req();
    bus.mem_busy = 1'b1; bus.flush = 1'b1;
    #1;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL fl_beat0 got %b@%h exp 1@300", bus.mem_ren, bus.mem_addr); end n_checks++;
    cyc();
    bus.flush = 1'b0; bus.mem_busy = 1'b0;
    #1;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL fl_hold got %b@%h exp 1@300", bus.mem_ren, bus.mem_addr); end n_checks++;
    cyc();
    #1;
    if ({bus.mem_ren, bus.reg_w, bus.busy, bus.req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL fl_idle got %b exp 0001", {bus.mem_ren, bus.reg_w, bus.busy, bus.req_ready});
    end
    n_checks++;
    // Flush arriving in DONE must kill the write-back.
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_addr = 32'h104;
    cyc();
    clr_req();
    cyc();
    bus.flush = 1'b1;
    #1;
    if (bus.reg_w !== 1'b0) begin n_fail++; $display("FAIL fl_done got %b exp 0", bus.reg_w); end n_checks++;
    cyc();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_dbl = 1'b1;
    bus.req_addr = 32'h208; bus.req_wdata = 64'h400921FB54442D18;
    cyc();
    clr_req();
    bus.mem_busy = 1'b1;
    #1;
    if (bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL rm_wen got %b exp 1", bus.mem_wen); end n_checks++;
    #2;
    nRST = 1'b0;
    #1;
    if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_store !== 32'h0) begin
      n_fail++; $display("FAIL rm_bus got %b %h %h exp 0 0 0", bus.mem_wen, bus.mem_addr, bus.mem_store);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_state got %b/%b exp 1/0", bus.req_ready, bus.busy); end n_checks++;
    cyc();
    nRST = 1'b1;
    bus.mem_busy = 1'b0;
    cyc();
    test_word_load(32'h100, 32'h3F800000, WL_EXP);
  endtask

  initial begin
    test_reset();
    test_word_load(32'h100, 32'h3F800000, WL_EXP);
    cyc();
    test_double_store();
    test_double_load();
    test_illegal(1'b1, 1'b0, 1'b1, 32'h204);
    test_illegal(1'b1, 1'b0, 1'b0, 32'h102);
    test_illegal(1'b1, 1'b1, 1'b0, 32'h100);
    test_ignore();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
